// File: rtl/bit_message_pkg.sv
// Shared definitions for the bit message printer.
//
// Contents:
//   state_t      - FSM state encoding (COLLECT, PRINT, WAIT, EOL)
//   BYTE_W       - width of a stored / transmitted byte
//   ASCII_*      - characters recognised on rx and emitted on tx
//   count_width  - width of the byte counter for a given buffer depth
//                  (one extra bit so the counter can hold MSG_DEPTH itself)
package bit_message_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRINT   = 2'd1,
    WAIT    = 2'd2,
    EOL     = 2'd3
  } state_t;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_1  = 8'h31;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bit_message_buffer.sv
// Message storage for the bit message printer.
//
// MSG_DEPTH bytes, synchronous write, combinational read. Contents are
// deliberately not reset.
//
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - byte to store
//   rd_addr  - read address
//   rd_data  - byte at rd_addr (combinational)
module bit_message_buffer
  import bit_message_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int AW        = $clog2(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [MSG_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bit_message_printer.sv
// Bit message printer: collects ASCII "0"/"1" characters, packs them MSB-first
// into bytes of BITS_PER_CHAR bits, stores the bytes, and on CR (or a full
// buffer) prints the stored bytes followed by CR LF.
//
// Optional feature: define BIT_MESSAGE_ECHO_EN to echo each accepted bit
// character on tx while collecting (skipped when tx is busy).
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   rx_data      - received character, valid when new_rx_data is high
//   new_rx_data  - one-cycle receive strobe
//   tx_busy      - transmitter cannot accept a byte
//   tx_data      - byte to transmit, held when new_tx_data is low
//   new_tx_data  - one-cycle transmit strobe
//   state        - current FSM state (debug)
//   count        - number of bytes stored
//   rx_dropped   - sticky: a character arrived while it could not be accepted
module bit_message_printer
  import bit_message_pkg::*;
#(
  parameter int MSG_DEPTH     = 16,
  parameter int BITS_PER_CHAR = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          rx_data,
  input  logic                                new_rx_data,
  input  logic                                tx_busy,
  output logic [7:0]                          tx_data,
  output logic                                new_tx_data,
  output logic [1:0]                          state,
  output logic [count_width(MSG_DEPTH)-1:0]   count,
  output logic                                rx_dropped
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int CW = count_width(MSG_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(MSG_DEPTH);
  localparam logic [3:0]    BPC  = 4'(BITS_PER_CHAR);

  state_t            cur_state;
  logic [CW-1:0]     rd_ptr;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              eol_lf;
  logic              wr_en;
  logic [7:0]        rd_byte;
  logic              is_bit;
  logic              will_be_full;
  logic              tx_ok;
  logic [7:0]        shift_base;
  logic [3:0]        bit_base;

  assign state = cur_state;

  // A completed byte is committed the cycle after its last bit arrived.
  assign wr_en = (cur_state == COLLECT) && (bit_cnt == BPC);

  // A bit arriving in the commit cycle starts the next byte from scratch.
  assign shift_base = wr_en ? 8'h00 : shift_reg;
  assign bit_base   = wr_en ? 4'd0  : bit_cnt;

  assign is_bit = (rx_data == ASCII_0) || (rx_data == ASCII_1);

  // Bits are refused once the buffer is, or is about to become, full.
  assign will_be_full = (count == FULL) || (wr_en && (count == FULL - CW'(1)));

  // The extra new_tx_data term keeps strobes at least one cycle apart.
  assign tx_ok = !tx_busy && !new_tx_data;

  bit_message_buffer #(
    .MSG_DEPTH(MSG_DEPTH),
    .AW       (AW)
  ) u_buffer (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(count[AW-1:0]),
    .wr_data(shift_reg),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rd_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= COLLECT;
      count       <= '0;
      rd_ptr      <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      eol_lf      <= 1'b0;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      rx_dropped  <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;

      if (wr_en) begin
        count     <= count + CW'(1);
        bit_cnt   <= '0;
        shift_reg <= '0;
      end

      if (new_rx_data && (cur_state != COLLECT)) rx_dropped <= 1'b1;

      unique case (cur_state)
        COLLECT: begin
          if (new_rx_data) begin
            if (rx_data == ASCII_CR) begin
              bit_cnt   <= '0;
              shift_reg <= '0;
              cur_state <= PRINT;
            end else if (is_bit) begin
              if (will_be_full) begin
                rx_dropped <= 1'b1;
              end else begin
                bit_cnt   <= bit_base + 4'd1;
                shift_reg <= {shift_base[6:0], rx_data[0]};
`ifdef BIT_MESSAGE_ECHO_EN
                if (tx_ok) begin
                  tx_data     <= rx_data;
                  new_tx_data <= 1'b1;
                end
`endif
              end
            end
          end
          if (count == FULL) cur_state <= PRINT;
        end

        PRINT: begin
          if (rd_ptr >= count) begin
            cur_state <= EOL;
          end else if (tx_ok) begin
            tx_data     <= rd_byte;
            new_tx_data <= 1'b1;
            rd_ptr      <= rd_ptr + CW'(1);
            cur_state   <= WAIT;
          end
        end

        // One idle cycle so the transmitter can raise tx_busy.
        WAIT: begin
          cur_state <= (rd_ptr < count) ? PRINT : EOL;
        end

        EOL: begin
          if (tx_ok) begin
            new_tx_data <= 1'b1;
            if (!eol_lf) begin
              tx_data   <= ASCII_CR;
              eol_lf    <= 1'b1;
              cur_state <= WAIT;
            end else begin
              tx_data   <= ASCII_LF;
              eol_lf    <= 1'b0;
              count     <= '0;
              rd_ptr    <= '0;
              bit_cnt   <= '0;
              shift_reg <= '0;
              cur_state <= COLLECT;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_message_printer.sv
// Self-checking bench for bit_message_printer.
// Three instances: A (16 bytes, 8 bits/char), B (2 bytes, 8 bits/char),
// C (16 bytes, 3 bits/char). Expected tx bytes are queued per instance when
// stimulus is issued; a monitor pops and compares on every new_tx_data pulse.
module tb_bit_message_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst         [3];
  logic [7:0] rx_data     [3];
  logic       new_rx_data [3];
  logic       tx_busy     [3];
  logic [7:0] tx_data     [3];
  logic       new_tx_data [3];
  logic [1:0] state       [3];
  logic       rx_dropped  [3];
  logic [4:0] count_a;
  logic [1:0] count_b;
  logic [4:0] count_c;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic busy_seen [3] = '{1'b0, 1'b0, 1'b0};
  logic prev_tx   [3] = '{1'b0, 1'b0, 1'b0};

  bit_message_printer #(.MSG_DEPTH(16), .BITS_PER_CHAR(8)) dut_a (
    .clk(clk), .rst(rst[0]), .rx_data(rx_data[0]), .new_rx_data(new_rx_data[0]),
    .tx_busy(tx_busy[0]), .tx_data(tx_data[0]), .new_tx_data(new_tx_data[0]),
    .state(state[0]), .count(count_a), .rx_dropped(rx_dropped[0]));

  bit_message_printer #(.MSG_DEPTH(2), .BITS_PER_CHAR(8)) dut_b (
    .clk(clk), .rst(rst[1]), .rx_data(rx_data[1]), .new_rx_data(new_rx_data[1]),
    .tx_busy(tx_busy[1]), .tx_data(tx_data[1]), .new_tx_data(new_tx_data[1]),
    .state(state[1]), .count(count_b), .rx_dropped(rx_dropped[1]));

  bit_message_printer #(.MSG_DEPTH(16), .BITS_PER_CHAR(3)) dut_c (
    .clk(clk), .rst(rst[2]), .rx_data(rx_data[2]), .new_rx_data(new_rx_data[2]),
    .tx_busy(tx_busy[2]), .tx_data(tx_data[2]), .new_tx_data(new_tx_data[2]),
    .state(state[2]), .count(count_c), .rx_dropped(rx_dropped[2]));

  task automatic checkValue(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pushExp(input int d, input logic [7:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic checkOutput(input int d, input logic [7:0] act);
    logic [7:0] exp;
    if (qsize(d) == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL tx_unexpected_%0d: got 0x%0h, expected no output", d, act);
    end else begin
      case (d)
        0:       exp = q0.pop_front();
        1:       exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      checkValue($sformatf("tx_data_%0d", d), int'(act), int'(exp));
    end
  endtask

  // Record tx_busy as the DUT sees it at the active edge.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) busy_seen[d] <= tx_busy[d];
  end

  // Monitor: every tx strobe is compared against the scoreboard and the
  // handshake rules (not while busy, never two cycles in a row).
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (new_tx_data[d] === 1'b1) begin
        checkOutput(d, tx_data[d]);
        checkValue($sformatf("tx_while_busy_%0d", d), int'(busy_seen[d]), 0);
        checkValue($sformatf("tx_back_to_back_%0d", d), int'(prev_tx[d]), 0);
      end
      prev_tx[d] = (new_tx_data[d] === 1'b1);
    end
  end

  task automatic applyStimulus(input int d, input logic [7:0] c);
    @(posedge clk); #1;
    rx_data[d]     = c;
    new_rx_data[d] = 1'b1;
    @(posedge clk); #1;
    new_rx_data[d] = 1'b0;
  endtask

  task automatic sendBit(input int d, input logic b);
    logic [7:0] c;
    c = b ? 8'h31 : 8'h30;
`ifdef BIT_MESSAGE_ECHO_EN
    pushExp(d, c);
`endif
    applyStimulus(d, c);
  endtask

  task automatic sendByte(input int d, input logic [7:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) sendBit(d, v[i]);
  endtask

  task automatic waitIdle(input int d, input int budget);
    int n;
    bit reached;
    n = 0;
    reached = 1'b0;
    while (!reached && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      reached = (state[d] == 2'd0) && (qsize(d) == 0) && !new_tx_data[d];
    end
    checkValue($sformatf("idle_reached_%0d", d), int'(reached), 1);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      rst[d]         = 1'b1;
      rx_data[d]     = 8'h00;
      new_rx_data[d] = 1'b0;
      tx_busy[d]     = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkValue("rst_state", int'(state[0]), 0);
    checkValue("rst_count", int'(count_a), 0);
    checkValue("rst_tx_data", int'(tx_data[0]), 0);
    checkValue("rst_new_tx", int'(new_tx_data[0]), 0);
    checkValue("rst_dropped", int'(rx_dropped[0]), 0);
    checkValue("rst_count_b", int'(count_b), 0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // 01010101 + CR -> 55 0D 0A
    $display("[TB] basic byte");
    sendByte(0, 8'h55, 8);
    pushExp(0, 8'h55); pushExp(0, 8'h0D); pushExp(0, 8'h0A);
    applyStimulus(0, 8'h0D);
    waitIdle(0, 100);
    checkValue("basic_count", int'(count_a), 0);
    checkValue("basic_dropped", int'(rx_dropped[0]), 0);

    // 3-bit chars with an ignored 'A' -> 07 0D 0A
    $display("[TB] 3-bit chars, ignored character");
    sendBit(2, 1'b1);
    sendBit(2, 1'b1);
    applyStimulus(2, 8'h41);
    sendBit(2, 1'b1);
    pushExp(2, 8'h07); pushExp(2, 8'h0D); pushExp(2, 8'h0A);
    applyStimulus(2, 8'h0D);
    waitIdle(2, 100);
    checkValue("ignore_dropped", int'(rx_dropped[2]), 0);
    checkValue("ignore_count", int'(count_c), 0);

    // Two-byte buffer fills and prints without CR
    $display("[TB] auto print on full buffer");
    for (int i = 0; i < 16; i++) sendBit(1, 1'b1);
    pushExp(1, 8'hFF); pushExp(1, 8'hFF); pushExp(1, 8'h0D); pushExp(1, 8'h0A);
    waitIdle(1, 100);
    checkValue("full_count", int'(count_b), 0);
    checkValue("full_dropped", int'(rx_dropped[1]), 0);

    // Empty buffer: CR -> 0D 0A
    $display("[TB] empty buffer");
    pushExp(0, 8'h0D); pushExp(0, 8'h0A);
    applyStimulus(0, 8'h0D);
    waitIdle(0, 100);

    // tx_busy held for 20 cycles during PRINT
    $display("[TB] busy stall");
    sendByte(0, 8'hA5, 8);
    sendByte(0, 8'h3C, 8);
    tx_busy[0] = 1'b1;
    pushExp(0, 8'hA5); pushExp(0, 8'h3C); pushExp(0, 8'h0D); pushExp(0, 8'h0A);
    applyStimulus(0, 8'h0D);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkValue("busy_no_output", qsize(0), 4);
    checkValue("busy_state", int'(state[0]), 1);
    checkValue("busy_count", int'(count_a), 2);
    @(posedge clk); #1;
    tx_busy[0] = 1'b0;
    waitIdle(0, 100);

    // Bit strobe during PRINT is dropped and sets the sticky flag
    $display("[TB] drop during print");
    sendByte(0, 8'h81, 8);
    tx_busy[0] = 1'b1;
    pushExp(0, 8'h81); pushExp(0, 8'h0D); pushExp(0, 8'h0A);
    applyStimulus(0, 8'h0D);
    applyStimulus(0, 8'h31);
    @(negedge clk);
    checkValue("drop_flag", int'(rx_dropped[0]), 1);
    checkValue("drop_count", int'(count_a), 1);
    @(posedge clk); #1;
    tx_busy[0] = 1'b0;
    waitIdle(0, 100);
    checkValue("drop_flag_sticky", int'(rx_dropped[0]), 1);

    // Reset after the first printed byte aborts the print
    $display("[TB] reset mid-print");
    sendByte(0, 8'h12, 8);
    sendByte(0, 8'h34, 8);
    pushExp(0, 8'h12);
    applyStimulus(0, 8'h0D);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state[0] != 2'd2 && n < 50);
    checkValue("abort_reached_wait", int'(state[0]), 2);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkValue("abort_state", int'(state[0]), 0);
    checkValue("abort_count", int'(count_a), 0);
    checkValue("abort_new_tx", int'(new_tx_data[0]), 0);
    checkValue("abort_dropped", int'(rx_dropped[0]), 0);
    rst[0] = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);

    checkValue("queue_empty_a", qsize(0), 0);
    checkValue("queue_empty_b", qsize(1), 0);
    checkValue("queue_empty_c", qsize(2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
